// File: rtl/devlink_activity_monitor.sv
// Per-channel devlink activity monitor: synchronise, optionally glitch-filter, detect edges, drive LEDs.
// Optional glitch filter enabled by defining DEVLINK_GLITCH_FILTER_EN.
module devlink_activity_monitor #(
    parameter int NUM_CH         = 8,
    parameter int STRETCH_CYCLES = 1000,
    parameter int STRETCH_W      = 16,
    parameter int CNT_W          = 16,
    parameter int FILT_LEN       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] devlink_in,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic [NUM_CH-1:0] led,
    output logic              activity_any,
    output logic [CNT_W-1:0]  evt_count
);

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_STRETCH = 2'b01,
        MODE_STICKY  = 2'b10,
        MODE_BLANK   = 2'b11
    } mode_t;

    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] f;
    logic [NUM_CH-1:0] f_d;
    logic [NUM_CH-1:0] e;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] sticky;
    logic [NUM_CH-1:0] sticky_next;
    logic [NUM_CH-1:0] led_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= devlink_in;
            s     <= sync1;
        end
    end

`ifdef DEVLINK_GLITCH_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    // f only moves after FILT_LEN consecutive samples disagree with it; any agreeing sample restarts the run.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_filt
        logic [3:0] run;
        logic       cand;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                run  <= '0;
                cand <= 1'b0;
                f[i] <= 1'b0;
            end else if (s[i] != f[i]) begin
                if (cand != s[i]) begin
                    cand <= s[i];
                    run  <= 4'd1;
                end else if (run == FILT_LAST) begin
                    f[i] <= s[i];
                    run  <= '0;
                end else begin
                    run <= run + 4'd1;
                end
            end else begin
                cand <= f[i];
                run  <= '0;
            end
        end
    end
`else
    assign f = s;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_d <= '0;
        end else begin
            f_d <= f;
        end
    end

    assign e = f ^ f_d;

    // Retrigger reloads rather than accumulates; the counter parks at zero.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stretch
        logic [STRETCH_W-1:0] cnt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (e[i]) begin
                cnt <= STRETCH_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end

        assign active[i] = (cnt != '0) | e[i];
    end

    // A new edge beats a simultaneous clear so the event is never lost.
    assign sticky_next = e | (sticky & ~{NUM_CH{clear}});

    always_comb begin
        led_next = '0;
        case (mode_t'(mode))
            MODE_DIRECT:  led_next = f;
            MODE_STRETCH: led_next = active;
            MODE_STICKY:  led_next = sticky_next;
            MODE_BLANK:   led_next = '0;
            default:      led_next = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky       <= '0;
            led          <= '0;
            activity_any <= 1'b0;
            evt_count    <= '0;
        end else begin
            sticky       <= sticky_next;
            led          <= led_next;
            activity_any <= |active;
            if (clear) begin
                evt_count <= '0;
            end else if ((|e) && (evt_count != {CNT_W{1'b1}})) begin
                evt_count <= evt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_devlink_activity_monitor.sv
// Directed bench for devlink_activity_monitor: vector table plus hand-written multi-cycle sequences.
module tb_devlink_activity_monitor;

    localparam int NUM_CH = 8;
    localparam int SC     = 20;
    localparam int CNT_W  = 4;
    localparam int FL     = 4;
`ifdef DEVLINK_GLITCH_FILTER_EN
    localparam int LAT = 3 + FL;
    localparam int TG  = FL + 2;
`else
    localparam int LAT = 3;
    localparam int TG  = 2;
`endif

    logic              clock;
    logic              reset;
    logic [NUM_CH-1:0] devlink_in;
    logic [1:0]        mode;
    logic              clear;
    logic [NUM_CH-1:0] led;
    logic              activity_any;
    logic [CNT_W-1:0]  evt_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] din;
        logic [1:0] mode;
        logic [7:0] exp_led;
        logic [3:0] exp_evt;
    } vec_t;

    vec_t vecs [6];

    devlink_activity_monitor #(
        .NUM_CH(NUM_CH),
        .STRETCH_CYCLES(SC),
        .STRETCH_W(16),
        .CNT_W(CNT_W),
        .FILT_LEN(FL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .devlink_in(devlink_in),
        .mode(mode),
        .clear(clear),
        .led(led),
        .activity_any(activity_any),
        .evt_count(evt_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    // Rising edge on ch0, falling edge gap clocks later, then watch the tail of the stretch.
    task automatic stretch_seq(input int gap);
        devlink_in[0] = 1'b1;
        for (int k = 1; k <= gap; k++) begin
            step(1);
            if (k >= LAT) begin
                check("stretch_hold", 32'(led[0]), 32'd1);
                check("stretch_act", 32'(activity_any), 32'd1);
            end
        end
        devlink_in[0] = 1'b0;
        for (int k = 1; k <= LAT + SC + 1; k++) begin
            step(1);
            check("stretch_tail", 32'(led[0]), (k <= LAT + SC) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        devlink_in = '0;
        mode       = 2'b00;
        clear      = 1'b0;

        vecs[0] = '{din: 8'hA5, mode: 2'b00, exp_led: 8'hA5, exp_evt: 4'd1};
        vecs[1] = '{din: 8'hA5, mode: 2'b11, exp_led: 8'h00, exp_evt: 4'd1};
        vecs[2] = '{din: 8'h5A, mode: 2'b00, exp_led: 8'h5A, exp_evt: 4'd2};
        vecs[3] = '{din: 8'h5A, mode: 2'b10, exp_led: 8'hFF, exp_evt: 4'd2};
        vecs[4] = '{din: 8'h0F, mode: 2'b01, exp_led: 8'hFF, exp_evt: 4'd3};
        vecs[5] = '{din: 8'h0F, mode: 2'b00, exp_led: 8'h0F, exp_evt: 4'd3};

        step(3);
        reset = 1'b0;
        step(1);
        check("reset_led", 32'(led), 32'h0);
        check("reset_act", 32'(activity_any), 32'h0);
        check("reset_evt", 32'(evt_count), 32'h0);
        step(LAT + 3);
        check("idle_evt", 32'(evt_count), 32'h0);

`ifdef DEVLINK_GLITCH_FILTER_EN
        begin
            logic seen;
            seen = 1'b0;
            devlink_in[2] = 1'b1;
            step(3);
            devlink_in[2] = 1'b0;
            for (int k = 0; k < 12; k++) begin
                step(1);
                seen = seen | led[2];
            end
            check("glitch_led", 32'(seen), 32'd0);
            check("glitch_evt", 32'(evt_count), 32'd0);
            devlink_in[2] = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                step(1);
                if (k == 5) devlink_in[2] = 1'b0;
                if (k == 6) check("pulse_early", 32'(led[2]), 32'd0);
                if (k == 7) check("pulse_lat7", 32'(led[2]), 32'd1);
            end
            step(12);
            check("pulse_end_led", 32'(led[2]), 32'd0);
            check("pulse_end_evt", 32'(evt_count), 32'd2);
        end
`endif

        pulse_clear();
        check("clear_evt", 32'(evt_count), 32'h0);
        for (int i = 0; i < 6; i++) begin
            devlink_in = vecs[i].din;
            mode       = vecs[i].mode;
            step(LAT);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_evt", i), 32'(evt_count), 32'(vecs[i].exp_evt));
        end
        check("table_act", 32'(activity_any), 32'd1);

        devlink_in = 8'h00;
        step(LAT + 2);
        pulse_clear();
        step(1);
        devlink_in = 8'hA5;
        step(LAT - 1);
        check("direct_early", 32'(led), 32'h00);
        step(1);
        check("direct_led", 32'(led), 32'hA5);
        check("direct_evt", 32'(evt_count), 32'd1);
        step(2);
        check("direct_evt_once", 32'(evt_count), 32'd1);

        mode = 2'b10;
        pulse_clear();
        check("sticky_cleared", 32'(led), 32'h00);
        devlink_in = 8'hAD;
        step(LAT);
        check("sticky_set", 32'(led), 32'h08);
        step(5);
        check("sticky_held", 32'(led), 32'h08);
        pulse_clear();
        check("sticky_clear", 32'(led), 32'h00);
        devlink_in = 8'hA5;
        step(LAT - 1);
        pulse_clear();
        check("sticky_set_wins", 32'(led), 32'h08);
        check("sticky_clr_evt", 32'(evt_count), 32'd0);
        step(3);
        check("sticky_after", 32'(led), 32'h08);

        mode = 2'b01;
        devlink_in = 8'h00;
        step(LAT + SC + 5);
        check("stretch_idle_act", 32'(activity_any), 32'd0);
        check("stretch_idle_led", 32'(led), 32'h00);
        stretch_seq(10);
        check("stretch_done_act", 32'(activity_any), 32'd0);
        stretch_seq(SC - 2);

        mode = 2'b00;
        step(2);
        pulse_clear();
        for (int k = 0; k < 20; k++) begin
            devlink_in[1] = ~devlink_in[1];
            step(TG);
        end
        step(LAT);
        check("sat_evt", 32'(evt_count), 32'd15);
        pulse_clear();
        check("sat_clear", 32'(evt_count), 32'd0);

        step(LAT + 2);
        pulse_clear();
        for (int k = 0; k < 5; k++) begin
            devlink_in[0] = ~devlink_in[0];
            step(TG);
        end
        step(LAT);
        mode = 2'b01;
        step(1);
        check("pre_reset_evt", 32'(evt_count), 32'd5);
        check("pre_reset_act", 32'(activity_any), 32'd1);
        check("pre_reset_led", 32'(led[0]), 32'd1);
        #3;
        reset      = 1'b1;
        devlink_in = 8'h00;
        #1;
        check("async_led", 32'(led), 32'h0);
        check("async_act", 32'(activity_any), 32'h0);
        check("async_evt", 32'(evt_count), 32'h0);
        step(2);
        reset = 1'b0;
        step(LAT + 3);
        check("post_reset_evt", 32'(evt_count), 32'h0);
        check("post_reset_act", 32'(activity_any), 32'h0);
        check("post_reset_led", 32'(led), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
